// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port memory between an instruction-fetch
// port (I, read-only) and a load/store port (D). One request is in flight at a time:
// IDLE grants, ISSUE drives the memory, WAIT covers extra read latency, RESP pulses back.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_rsp_valid,
  output logic [DATA_WIDTH-1:0] i_rsp_rdata,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_rdata,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic OwnerI = 1'b0;
  localparam logic OwnerD = 1'b1;
  // WAIT runs READ_LATENCY-1 cycles: counts WaitInit down to zero inclusive.
  localparam logic [1:0] WaitInit = (READ_LATENCY >= 2) ? 2'(READ_LATENCY - 2) : 2'd0;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [1:0]            wait_cnt_q, wait_cnt_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic grant_valid;
  logic grant_owner;
  logic resp_active;

  // Grant offered only in IDLE (and never in a reset cycle); ties go to the port not served last
  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OwnerI;
    if (state_q == StIdle && !rst) begin
      if (i_req_valid && d_req_valid) begin
        grant_valid = 1'b1;
        grant_owner = ~last_grant_q;
      end else if (i_req_valid) begin
        grant_valid = 1'b1;
        grant_owner = OwnerI;
      end else if (d_req_valid) begin
        grant_valid = 1'b1;
        grant_owner = OwnerD;
      end
    end
  end

  assign i_req_ready = grant_valid && (grant_owner == OwnerI);
  assign d_req_ready = grant_valid && (grant_owner == OwnerD);

  // Next-state logic and request latching
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d      = StIssue;
          last_grant_d = grant_owner;
          owner_d      = grant_owner;
          // Fetch port has no write path
          we_d         = (grant_owner == OwnerD) && d_req_we;
          addr_d       = (grant_owner == OwnerD) ? d_req_addr : i_req_addr;
          wdata_d      = (grant_owner == OwnerD) ? d_req_wdata : '0;
        end
      end
      StIssue: begin
        if (we_q || READ_LATENCY == 1) begin
          state_d = StResp;
        end else begin
          wait_cnt_d = WaitInit;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (wait_cnt_q == 2'd0) begin
          state_d = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset; an in-flight request is simply dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= OwnerD;
      wait_cnt_q   <= 2'd0;
      owner_q      <= OwnerI;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Memory drive and response outputs; address/data held from ISSUE through RESP
  always_comb begin
    resp_active      = (state_q == StResp) && !rst;
    i_rsp_valid      = resp_active && (owner_q == OwnerI);
    d_rsp_valid      = resp_active && (owner_q == OwnerD);
    i_rsp_rdata      = i_rsp_valid ? mem_data_out : '0;
    d_rsp_rdata      = (d_rsp_valid && !we_q) ? mem_data_out : '0;
    // Not gated by rst: a store caught by reset in ISSUE still lands in memory
    mem_write_enable = (state_q == StIssue) && we_q;
    mem_address      = (state_q != StIdle) ? addr_q : '0;
    mem_data_in      = (state_q != StIdle) ? wdata_q : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a READ_LATENCY=1 instance checked every cycle against a
// transaction-level model, and a READ_LATENCY=3 instance for latency and mid-flight reset.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance with READ_LATENCY = 1
  logic        i1_v, i1_rdy, i1_rv, d1_v, d1_rdy, d1_we, d1_rv, m1_we;
  logic [31:0] i1_a, i1_rd, d1_a, d1_wd, d1_rd, m1_addr, m1_din, m1_dout;
  // Instance with READ_LATENCY = 3
  logic        i3_v, i3_rdy, i3_rv, d3_v, d3_rdy, d3_we, d3_rv, m3_we;
  logic [31:0] i3_a, i3_rd, d3_a, d3_wd, d3_rd, m3_addr, m3_din, m3_dout;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req_valid(i1_v), .i_req_ready(i1_rdy), .i_req_addr(i1_a),
    .i_rsp_valid(i1_rv), .i_rsp_rdata(i1_rd),
    .d_req_valid(d1_v), .d_req_ready(d1_rdy), .d_req_we(d1_we), .d_req_addr(d1_a),
    .d_req_wdata(d1_wd), .d_rsp_valid(d1_rv), .d_rsp_rdata(d1_rd),
    .mem_write_enable(m1_we), .mem_address(m1_addr), .mem_data_in(m1_din),
    .mem_data_out(m1_dout)
  );

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .i_req_valid(i3_v), .i_req_ready(i3_rdy), .i_req_addr(i3_a),
    .i_rsp_valid(i3_rv), .i_rsp_rdata(i3_rd),
    .d_req_valid(d3_v), .d_req_ready(d3_rdy), .d_req_we(d3_we), .d_req_addr(d3_a),
    .d_req_wdata(d3_wd), .d_rsp_valid(d3_rv), .d_rsp_rdata(d3_rd),
    .mem_write_enable(m3_we), .mem_address(m3_addr), .mem_data_in(m3_din),
    .mem_data_out(m3_dout)
  );

  // Memories: registered read with 1 and 3 cycles of latency, low 8 address bits decoded
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] p3 [3];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_a  = 8'h00;
  logic [31:0] pl_d  = 32'h0;

  always @(posedge clk) begin
    if (pl_we) begin
      mem1[pl_a] <= pl_d;
      mem3[pl_a] <= pl_d;
    end
    if (m1_we) mem1[m1_addr[7:0]] <= m1_din;
    if (m3_we) mem3[m3_addr[7:0]] <= m3_din;
    m1_dout <= mem1[m1_addr[7:0]];
    p3[0]   <= mem3[m3_addr[7:0]];
    p3[1]   <= p3[0];
    p3[2]   <= p3[1];
  end
  assign m3_dout = p3[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model of u_dut1: m_t counts cycles since accept (0 = idle)
  logic [31:0] ref1 [256];
  int          m_t, m_end;
  bit          m_owner, m_we, m_last, e_gv, e_go, e_rsp;
  logic [31:0] m_addr, m_wdata;

  initial begin
    for (int j = 0; j < 256; j++) ref1[j] = 32'h0;
    m_t = 0; m_last = 1'b1; m_owner = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (pl_we) ref1[pl_a] = pl_d;
      e_gv = 1'b0;
      e_go = 1'b0;
      if (!rst && m_t == 0) begin
        if (i1_v && d1_v) begin e_gv = 1'b1; e_go = ~m_last; end
        else if (i1_v)    begin e_gv = 1'b1; e_go = 1'b0; end
        else if (d1_v)    begin e_gv = 1'b1; e_go = 1'b1; end
      end
      m_end = m_we ? 2 : 2;  // RESP sits at 1 + READ_LATENCY for loads, 2 for stores
      e_rsp = !rst && m_t != 0 && m_t == m_end;
      check("m_i_ready", i1_rdy, e_gv && !e_go);
      check("m_d_ready", d1_rdy, e_gv && e_go);
      check("m_i_rsp_valid", i1_rv, e_rsp && !m_owner);
      check("m_d_rsp_valid", d1_rv, e_rsp && m_owner);
      check("m_i_rsp_rdata", i1_rd, (e_rsp && !m_owner) ? ref1[m_addr[7:0]] : 32'h0);
      check("m_d_rsp_rdata", d1_rd, (e_rsp && m_owner && !m_we) ? ref1[m_addr[7:0]] : 32'h0);
      check("m_mem_we", m1_we, m_t == 1 && m_we);
      check("m_mem_address", m1_addr, (m_t != 0) ? m_addr : 32'h0);
      if (m_t == 1 && m_we) check("m_mem_data_in", m1_din, m_wdata);
      // Advance the model to the next cycle
      if (m_t == 1 && m_we) ref1[m_addr[7:0]] = m_wdata;
      if (rst) begin
        m_t = 0; m_last = 1'b1;
      end else if (m_t == 0) begin
        if (e_gv) begin
          m_t = 1; m_owner = e_go; m_last = e_go; m_we = e_go && d1_we;
          m_addr = e_go ? d1_a : i1_a; m_wdata = e_go ? d1_wd : 32'h0;
        end
      end else if (m_t == m_end) begin
        m_t = 0;
      end else begin
        m_t++;
      end
    end
  end

  // Response capture for u_dut1
  logic [31:0] iq [$];
  logic [31:0] dq [$];
  initial begin
    forever begin
      @(negedge clk);
      if (i1_rv) iq.push_back(i1_rd);
      if (d1_rv) dq.push_back(d1_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    tick();
    pl_we = 1'b0;
  endtask

  // One D-port request on u_dut1; lat counts cycles from accept edge to the response cycle
  task automatic d_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat, output int wes);
    bit ok = 1'b0;
    d1_v = 1'b1; d1_we = we; d1_a = a; d1_wd = wd;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = d1_rdy;
      tick();
    end
    d1_v = 1'b0; d1_we = 1'b0;
    check("d_accept", ok, 1);
    ok = 1'b0; lat = 0; wes = 0; rd = 32'hffffffff;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      lat++;
      wes += int'(m1_we);
      if (d1_rv) begin ok = 1'b1; rd = d1_rd; end
      tick();
    end
    check("d_rsp_seen", ok, 1);
  endtask

  // One request on u_dut3; rst_at > 0 pulses rst during that cycle after accept
  task automatic b_txn(input bit is_d, input logic [31:0] a, input int rst_at,
                       output logic [31:0] rd, output int lat, output bit got,
                       output int addr_bad, output int acc_wait);
    bit ok = 1'b0;
    acc_wait = 0;
    if (is_d) begin d3_v = 1'b1; d3_a = a; end
    else      begin i3_v = 1'b1; i3_a = a; end
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      acc_wait++;
      ok = is_d ? d3_rdy : i3_rdy;
      tick();
    end
    d3_v = 1'b0; i3_v = 1'b0;
    check("b_accept", ok, 1);
    got = 1'b0; lat = 0; rd = 32'hffffffff; addr_bad = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (lat + 1 == rst_at) rst = 1'b1;
      @(negedge clk);
      lat++;
      if (m3_addr !== a) addr_bad++;
      got = is_d ? d3_rv : i3_rv;
      if (got) rd = is_d ? d3_rd : i3_rd;
      tick();
      rst = 1'b0;
    end
  endtask

  bit          ai, ad, got;
  bit          gq [$];
  int          ni, nd, lat, wes, abad, await_n, w_rdy, w_we;
  logic [31:0] rd;

  initial begin
    i1_v = 0; i1_a = 0; d1_v = 0; d1_we = 0; d1_a = 0; d1_wd = 0;
    i3_v = 0; i3_a = 0; d3_v = 0; d3_we = 0; d3_a = 0; d3_wd = 0;
    rst = 1'b1;
    tick();
    tick();
    for (int j = 0; j < 8; j++) preload(8'(8'h12 + j), 32'(2 * j));
    preload(8'h10, 32'h55);
    preload(8'h20, 32'h77);

    // Reset held with both valids high: nothing granted, all outputs quiet
    i1_v = 1'b1; i1_a = 32'h12; d1_v = 1'b1; d1_we = 1'b0; d1_a = 32'h13;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_i_ready", i1_rdy, 0);
      check("rst_d_ready", d1_rdy, 0);
      check("rst_mem_addr", m1_addr, 0);
      check("rst_mem_we", m1_we, 0);
      check("rst_i_rsp", i1_rv, 0);
      check("rst_d_rsp", d1_rv, 0);
      tick();
    end
    rst = 1'b0;

    // Contention: both ports stay valid, I takes even addresses, D odd ones
    ni = 0; nd = 0;
    for (int c = 0; c < 60 && (ni < 4 || nd < 4); c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("first_grant_i", i1_rdy, 1);
        check("first_grant_d", d1_rdy, 0);
      end
      ai = i1_v && i1_rdy;
      ad = d1_v && d1_rdy;
      if (ai) gq.push_back(1'b0);
      if (ad) gq.push_back(1'b1);
      tick();
      if (ai) begin
        ni++;
        i1_a = 32'h12 + 32'(2 * ni);
        if (ni == 4) i1_v = 1'b0;
      end
      if (ad) begin
        nd++;
        d1_a = 32'h13 + 32'(2 * nd);
        if (nd == 4) d1_v = 1'b0;
      end
    end
    check("contention_done", ni + nd, 8);
    repeat (4) tick();
    check("grant_count", gq.size(), 8);
    for (int k = 0; k < gq.size(); k++) check("grant_order", gq[k], k % 2);
    check("i_rsp_count", iq.size(), 4);
    check("d_rsp_count", dq.size(), 4);
    for (int k = 0; k < iq.size(); k++) check("i_rsp_data", iq[k], 32'(4 * k));
    for (int k = 0; k < dq.size(); k++) check("d_rsp_data", dq[k], 32'(4 * k + 2));

    // Store then load round trip
    d_txn(1'b1, 32'h8542391A, 32'hdeadbeef, rd, lat, wes);
    check("st_latency", lat, 2);
    check("st_rdata", rd, 0);
    check("st_we_cycles", wes, 1);
    d_txn(1'b0, 32'h8542391A, 32'h0, rd, lat, wes);
    check("ld_latency", lat, 2);
    check("ld_rdata", rd, 32'hdeadbeef);
    check("ld_we_cycles", wes, 0);

    // Withdrawal: D raises a store for one cycle while I owns the arbiter
    i1_v = 1'b1; i1_a = 32'h14;
    @(negedge clk);
    check("wd_i_grant", i1_rdy, 1);
    tick();
    i1_v = 1'b0; d1_v = 1'b1; d1_we = 1'b1; d1_a = 32'h30; d1_wd = 32'h1234;
    w_rdy = 0; w_we = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      w_rdy += int'(d1_rdy);
      w_we  += int'(m1_we);
      tick();
      d1_v = 1'b0; d1_we = 1'b0;
    end
    check("wd_d_ready", w_rdy, 0);
    check("wd_mem_we", w_we, 0);

    // READ_LATENCY = 3: load of 0x10 returns 0x55 four cycles after accept
    b_txn(1'b1, 32'h10, 0, rd, lat, got, abad, await_n);
    check("lat3_seen", got, 1);
    check("lat3_latency", lat, 4);
    check("lat3_rdata", rd, 32'h55);
    check("lat3_addr_hold", abad, 0);

    // Reset during WAIT of a fetch: response is dropped, next fetch completes
    b_txn(1'b0, 32'h20, 2, rd, lat, got, abad, await_n);
    check("rst_mid_no_rsp", got, 0);
    b_txn(1'b0, 32'h20, 0, rd, lat, got, abad, await_n);
    check("post_rst_idle", await_n, 1);
    check("post_rst_seen", got, 1);
    check("post_rst_latency", lat, 4);
    check("post_rst_rdata", rd, 32'h77);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port unified `memory` block (clk, write_enable, address, data_in, data_out) between an instruction-fetch requester (port I, read-only) and a load/store requester (port D, read/write). It accepts at most one request at a time through a valid/ready handshake. It sequences the memory's address and write-enable, waits the memory read latency, then returns a one-cycle response pulse to the granted port. Round-robin grant keeps either port from being starved. It sits between the core's fetch/LSU stages and `memory`, and lets later multi-cycle cores keep a single memory instance.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width on all ports, passed unmodified to memory
- DATA_WIDTH, 32, data width on all ports
- READ_LATENCY, 1, cycles from the edge that samples mem_address until mem_data_out is valid; legal range 1..4

Ports:
- clk  input  1  single clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- i_req_valid  input  1  fetch request valid
- i_req_ready  output  1  fetch request accepted this cycle
- i_req_addr  input  ADDR_WIDTH  fetch address
- i_rsp_valid  output  1  one-cycle fetch response pulse
- i_rsp_rdata  output  DATA_WIDTH  fetch read data, valid with i_rsp_valid
- d_req_valid  input  1  load/store request valid
- d_req_ready  output  1  load/store request accepted this cycle
- d_req_we  input  1  1 = store, 0 = load
- d_req_addr  input  ADDR_WIDTH  load/store address
- d_req_wdata  input  DATA_WIDTH  store data
- d_rsp_valid  output  1  one-cycle load/store response pulse; stores also get this pulse as an acknowledge
- d_rsp_rdata  output  DATA_WIDTH  load data; 0 for store acknowledges
- mem_write_enable  output  1  to memory write_enable
- mem_address  output  ADDR_WIDTH  to memory address
- mem_data_in  output  DATA_WIDTH  to memory data_in
- mem_data_out  input  DATA_WIDTH  from memory data_out

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. A latched request holds owner, we, addr and wdata. last_grant is a 1-bit register; wait_cnt is a 2-bit counter.
- IDLE:
  - If exactly one port is valid, grant it.
  - If both are valid, grant the port not equal to last_grant.
  - x_req_ready = 1 combinationally, for the granted port only. Ready is never asserted outside IDLE.
  - On the valid&&ready edge: latch the request, set last_grant to the owner, go to ISSUE.
- ISSUE:
  - mem_address = latched addr.
  - Store: mem_data_in = latched wdata, mem_write_enable = 1 for exactly this cycle, then go to RESP.
  - Load/fetch: mem_write_enable = 0. If READ_LATENCY == 1 go to RESP; otherwise load wait_cnt = READ_LATENCY-2 and go to WAIT.
- WAIT: decrement wait_cnt; go to RESP when wait_cnt == 0.
- RESP:
  - Owner's rsp_valid = 1 for one cycle.
  - Load/fetch: rsp_rdata = mem_data_out, combinational pass-through. Store: rsp_rdata = 0.
  - Go to IDLE unconditionally.
- mem_address and mem_data_in hold the latched values from ISSUE through RESP. This makes registered-read and combinational-read memories both valid.
- Outside ISSUE, mem_write_enable = 0.
- Non-owner rsp_valid = 0 at all times. Both rsp_rdata buses = 0 when their rsp_valid is 0.
- Requesters must hold valid and payload stable until ready. Dropping valid before ready is legal and simply withdraws the request.
- Responses carry no back-pressure; requesters must consume the pulse.
- Fetch port has no write path; it never drives mem_write_enable.

## Timing
- Reset values:
  - state = IDLE.
  - last_grant = D, so port I wins the first contention.
  - wait_cnt = 0.
  - All outputs 0: ready, rsp_valid, rsp_rdata, mem_write_enable, mem_address, mem_data_in.
- Ready in IDLE is combinational from the valids, so it is 0 in the reset cycle itself.
- Load/fetch latency from the accept edge to the rsp_valid cycle is 1 + READ_LATENCY cycles. With READ_LATENCY = 1 that is 2, and the minimum request spacing is 3 cycles.
- Store latency is 2 cycles: write in ISSUE, ack in RESP.
- Simultaneous valid in IDLE: strict alternation I, D, I, D… for as long as both stay asserted.
- A new request arriving in the same cycle as a RESP is not accepted until the following IDLE cycle.
- rst asserted in any state:
  - Return to IDLE next edge and apply all reset values.
  - An in-flight request is dropped with no response.
  - If rst arrives in ISSUE of a store, the write still occurs that edge. The memory samples it; the arbiter does not retract it.
- Address is passed through unmodified; memory decoding and wrap-around are memory's concern.

## Test plan
- Reset: hold rst 2 cycles with both valids high → both readies 0, all outputs 0. The first cycle after reset grants I (i_req_ready = 1, d_req_ready = 0).
- Store/load round trip: D store addr 0x8542391A, data 0xdeadbeef → mem_write_enable high exactly 1 cycle and d_rsp_valid 2 cycles after accept with rdata 0. A following D load of the same address → d_rsp_rdata = 0xdeadbeef, 2 cycles after accept.
- Contention: I and D both valid continuously with 8 requests (addresses 0x12..0x19 preloaded with i*2) → grants alternate I, D, I, D… Every response goes to the correct port with the correct data; no port waits more than one other transaction.
- Latency: READ_LATENCY = 3 with a load of address 0x10 preloaded to 0x55 → rsp_valid exactly 4 cycles after accept. mem_address stays 0x10 from ISSUE through RESP.
- Reset mid-operation: assert rst during WAIT of a fetch → no i_rsp_valid is ever produced for it. The FSM is in IDLE after the edge, and the next request completes normally.
- Withdrawal: D valid for 1 cycle while I owns the arbiter, then deasserted → D is never granted, and mem_write_enable stays 0.
